// File: rtl/lane_arb_pkg.sv
// Shared lane count, select widths, FSM encoding and the round-robin pick function
// for the lane arbiter and its data-path mux.
package lane_arb_pkg;

    localparam int NUM_LANES = 8;
    localparam int SEL_W     = 4;
    localparam int LANE_W    = 3;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arbState_t;

    typedef struct packed {
        logic              found;
        logic [LANE_W-1:0] lane;
    } rrPick_t;

    // The scan starts one past the previous winner, so the previous winner is checked last.
    function automatic rrPick_t next_rr(input logic [NUM_LANES-1:0] req,
                                        input logic [LANE_W-1:0]    lastGrant);
        rrPick_t           pick;
        logic [LANE_W-1:0] idx;
        pick = '0;
        for (int k = 1; k <= NUM_LANES; k++) begin
            idx = lastGrant + LANE_W'(k);
            if (!pick.found && req[idx]) begin
                pick.found = 1'b1;
                pick.lane  = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux8.sv
// 8:1 64-bit lane multiplexer; select values 8..15 return zero.
module mux8 (
    input  logic [3:0]  i_sel,
    input  logic [63:0] in_1,
    input  logic [63:0] in_2,
    input  logic [63:0] in_3,
    input  logic [63:0] in_4,
    input  logic [63:0] in_5,
    input  logic [63:0] in_6,
    input  logic [63:0] in_7,
    input  logic [63:0] in_8,
    output logic [63:0] o_data
);

    always_comb begin
        o_data = '0;
        case (i_sel)
            4'd0:    o_data = in_1;
            4'd1:    o_data = in_2;
            4'd2:    o_data = in_3;
            4'd3:    o_data = in_4;
            4'd4:    o_data = in_5;
            4'd5:    o_data = in_6;
            4'd6:    o_data = in_7;
            4'd7:    o_data = in_8;
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/lane_rr_arbiter.sv
// Round-robin burst scheduler sharing one 64-bit output bus among 8 show-ahead lanes,
// with a registered valid/ready output stage.
module lane_rr_arbiter
    import lane_arb_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int DATA_W    = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 arb_en,
    input  logic [NUM_LANES-1:0] req,
    input  logic [DATA_W-1:0]    lane_data_1,
    input  logic [DATA_W-1:0]    lane_data_2,
    input  logic [DATA_W-1:0]    lane_data_3,
    input  logic [DATA_W-1:0]    lane_data_4,
    input  logic [DATA_W-1:0]    lane_data_5,
    input  logic [DATA_W-1:0]    lane_data_6,
    input  logic [DATA_W-1:0]    lane_data_7,
    input  logic [DATA_W-1:0]    lane_data_8,
    output logic [NUM_LANES-1:0] pop,
    output logic [SEL_W-1:0]     mux_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [LANE_W-1:0]    out_lane,
    output logic                 out_last,
    output logic                 busy
);

    localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

    arbState_t             r_state;
    arbState_t             w_stateNext;
    logic [LANE_W-1:0]     r_lastGrant;
    logic [LANE_W-1:0]     r_curLane;
    logic [3:0]            r_beatCnt;
    logic                  r_outValid;
    logic [DATA_W-1:0]     r_outData;
    logic [LANE_W-1:0]     r_outLane;
    logic                  r_outLast;

    rrPick_t               w_pick;
    logic                  w_canLoad;
    logic                  w_beat;
    logic                  w_start;
    logic                  w_lastBeat;
    logic [NUM_LANES-1:0]  w_pop;
    logic [SEL_W-1:0]      w_muxSel;
    logic [DATA_W-1:0]     w_muxData;

    mux8 u_mux (
        .i_sel  (w_muxSel),
        .in_1   (lane_data_1),
        .in_2   (lane_data_2),
        .in_3   (lane_data_3),
        .in_4   (lane_data_4),
        .in_5   (lane_data_5),
        .in_6   (lane_data_6),
        .in_7   (lane_data_7),
        .in_8   (lane_data_8),
        .o_data (w_muxData)
    );

    // A lane dropping req mid-burst ends the burst without a beat, so no out_last is produced.
    always_comb begin
        w_pick      = next_rr(req, r_lastGrant);
        w_canLoad   = ~r_outValid | out_ready;
        w_lastBeat  = (r_beatCnt == LAST_BEAT);
        w_stateNext = r_state;
        w_muxSel    = '0;
        w_pop       = '0;
        w_beat      = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            IDLE: begin
                if (arb_en && w_pick.found) begin
                    w_start     = 1'b1;
                    w_stateNext = XFER;
                end
            end
            XFER: begin
                w_muxSel = {1'b0, r_curLane};
                if (!req[r_curLane]) begin
                    w_stateNext = IDLE;
                end else if (w_canLoad) begin
                    w_beat           = 1'b1;
                    w_pop[r_curLane] = 1'b1;
                    if (w_lastBeat) begin
                        w_stateNext = IDLE;
                    end
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_lastGrant <= LANE_W'(NUM_LANES - 1);
            r_curLane   <= '0;
            r_beatCnt   <= '0;
        end else begin
            r_state <= w_stateNext;
            if (w_start) begin
                r_curLane   <= w_pick.lane;
                r_lastGrant <= w_pick.lane;
                r_beatCnt   <= '0;
            end else if (w_beat) begin
                r_beatCnt <= r_beatCnt + 4'd1;
            end
        end
    end

    // A new beat overwrites a beat being accepted in the same cycle, keeping out_valid high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outLane  <= '0;
            r_outLast  <= 1'b0;
        end else if (w_beat) begin
            r_outValid <= 1'b1;
            r_outData  <= w_muxData;
            r_outLane  <= r_curLane;
            r_outLast  <= w_lastBeat;
        end else if (r_outValid && out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    assign pop       = w_pop;
    assign mux_sel   = w_muxSel;
    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign out_lane  = r_outLane;
    assign out_last  = r_outLast;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_lane_rr_arbiter.sv
// Scoreboard bench for lane_rr_arbiter: bench-owned lane FIFOs advance on pop, expected
// beats are queued per test and compared at each output handshake.
module tb_lane_rr_arbiter;
    import lane_arb_pkg::*;

    localparam int BURST = 4;

    typedef struct {
        int          lane;
        int unsigned seq;
        bit          last;
        int          gap;
    } beatExp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 arb_en;
    logic [NUM_LANES-1:0] req;
    logic [63:0]          lane_data_1, lane_data_2, lane_data_3, lane_data_4;
    logic [63:0]          lane_data_5, lane_data_6, lane_data_7, lane_data_8;
    logic [NUM_LANES-1:0] pop;
    logic [SEL_W-1:0]     mux_sel;
    logic                 out_valid;
    logic                 out_ready;
    logic [63:0]          out_data;
    logic [LANE_W-1:0]    out_lane;
    logic                 out_last;
    logic                 busy;

    int unsigned          laneSeq [NUM_LANES] = '{default: 0};
    int unsigned          expSeq  [NUM_LANES] = '{default: 0};
    logic [NUM_LANES-1:0] popSeen = '0;
    beatExp_t             sbQ[$];
    int                   checkCount = 0;
    int                   failCount  = 0;
    int                   cycleCnt   = 0;
    int                   lastHs     = 0;
    bit                   checkOn    = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [63:0] mkData(input int lane, input int unsigned seq);
        return {8'(lane), 24'h0, seq};
    endfunction

    assign lane_data_1 = mkData(0, laneSeq[0]);
    assign lane_data_2 = mkData(1, laneSeq[1]);
    assign lane_data_3 = mkData(2, laneSeq[2]);
    assign lane_data_4 = mkData(3, laneSeq[3]);
    assign lane_data_5 = mkData(4, laneSeq[4]);
    assign lane_data_6 = mkData(5, laneSeq[5]);
    assign lane_data_7 = mkData(6, laneSeq[6]);
    assign lane_data_8 = mkData(7, laneSeq[7]);

    lane_rr_arbiter #(.BURST_LEN(BURST), .DATA_W(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .arb_en     (arb_en),
        .req        (req),
        .lane_data_1(lane_data_1),
        .lane_data_2(lane_data_2),
        .lane_data_3(lane_data_3),
        .lane_data_4(lane_data_4),
        .lane_data_5(lane_data_5),
        .lane_data_6(lane_data_6),
        .lane_data_7(lane_data_7),
        .lane_data_8(lane_data_8),
        .pop        (pop),
        .mux_sel    (mux_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_lane   (out_lane),
        .out_last   (out_last),
        .busy       (busy)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Lane heads advance one entry after every cycle whose pop was observed.
    always @(posedge clk) begin
        cycleCnt <= cycleCnt + 1;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (popSeen[i]) laneSeq[i] <= laneSeq[i] + 1;
        end
    end

    always @(negedge clk) begin
        beatExp_t e;
        popSeen = pop;
        if (checkOn) begin
            checkOutput("popLegal", 64'(pop & ~req), 64'h0);
            checkOutput("popOneHot", 64'($countones(pop) <= 1), 64'h1);
            if (rst_n && out_valid && out_ready) begin
                if (sbQ.size() == 0) begin
                    checkOutput("spuriousBeat", 64'(out_valid), 64'h0);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("outLane", 64'(out_lane), 64'(e.lane));
                    checkOutput("outData", out_data, mkData(e.lane, e.seq));
                    checkOutput("outLast", 64'(out_last), 64'(e.last));
                    if (e.gap != 0) checkOutput("beatGap", 64'(cycleCnt - lastHs), 64'(e.gap));
                end
                lastHs = cycleCnt;
            end
        end
    end

    task automatic applyStimulus(input logic [NUM_LANES-1:0] reqVal, input logic readyVal);
        req       = reqVal;
        out_ready = readyVal;
    endtask

    task automatic syncExpected();
        for (int i = 0; i < NUM_LANES; i++) expSeq[i] = laneSeq[i];
        sbQ.delete();
    endtask

    task automatic pushBeat(input int lane, input bit last, input int gap);
        beatExp_t e;
        e.lane = lane;
        e.seq  = expSeq[lane];
        e.last = last;
        e.gap  = gap;
        expSeq[lane]++;
        sbQ.push_back(e);
    endtask

    task automatic pushBurst(input int lane, input int firstGap);
        for (int b = 0; b < BURST; b++) pushBeat(lane, b == BURST - 1, (b == 0) ? firstGap : 1);
    endtask

    task automatic applyReset(input int nCycles, input logic [NUM_LANES-1:0] reqVal);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        applyStimulus(reqVal, 1'b1);
        repeat (nCycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
        syncExpected();
    endtask

    task automatic runUntilEmpty(input int maxCycles);
        int n = 0;
        while (sbQ.size() != 0 && n < maxCycles) begin
            @(posedge clk);
            n++;
        end
        if (sbQ.size() != 0) begin
            checkOutput("drainTimeout", 64'(sbQ.size()), 64'h0);
            sbQ.delete();
        end
        #1;
        applyStimulus('0, 1'b1);
        repeat (3) @(posedge clk);
    endtask

    task automatic waitPops(input int lane, input int count, input string tag);
        int seen = 0;
        int t = 0;
        while (seen < count && t < 30) begin
            @(negedge clk);
            if (pop[lane]) seen++;
            t++;
        end
        if (seen < count) checkOutput(tag, 64'(seen), 64'(count));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: got no finish expected finish");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int unsigned base;
        rst_n  = 1'b0;
        arb_en = 1'b1;
        applyStimulus(8'hFF, 1'b1);

        // reset held 3 cycles with all lanes requesting
        repeat (3) begin
            @(posedge clk);
            checkOn = 1'b1;
            @(negedge clk);
            checkOutput("rstPop", 64'(pop), 64'h0);
            checkOutput("rstValid", 64'(out_valid), 64'h0);
            checkOutput("rstData", out_data, 64'h0);
            checkOutput("rstLane", 64'(out_lane), 64'h0);
            checkOutput("rstBusy", 64'(busy), 64'h0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        syncExpected();
        pushBurst(0, 0);
        runUntilEmpty(40);

        // single lane, two back-to-back bursts with one bubble
        applyReset(1, '0);
        applyStimulus(8'h08, 1'b1);
        pushBurst(3, 0);
        pushBurst(3, 2);
        runUntilEmpty(60);

        // all lanes: rotation 0..7 then wrap to 0
        applyReset(1, '0);
        applyStimulus(8'hFF, 1'b1);
        pushBurst(0, 0);
        for (int l = 1; l < NUM_LANES; l++) pushBurst(l, 2);
        pushBurst(0, 2);
        runUntilEmpty(120);

        // backpressure for 3 cycles after beat 2 of a lane 5 burst
        applyReset(1, '0);
        applyStimulus(8'h20, 1'b1);
        base = expSeq[5];
        pushBeat(5, 1'b0, 0);
        pushBeat(5, 1'b0, 0);
        pushBeat(5, 1'b0, 1);
        pushBeat(5, 1'b1, 1);
        waitPops(5, 2, "bpStartTimeout");
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("bpPop", 64'(pop), 64'h0);
            checkOutput("bpValid", 64'(out_valid), 64'h1);
            checkOutput("bpData", out_data, mkData(5, base + 1));
            checkOutput("bpBusy", 64'(busy), 64'h1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        runUntilEmpty(40);

        // early termination of lane 6, then lane 7, then lane 0 ahead of lane 7
        applyReset(1, '0);
        applyStimulus(8'hC0, 1'b1);
        pushBeat(6, 1'b0, 0);
        pushBeat(6, 1'b0, 1);
        pushBurst(7, 3);
        pushBurst(0, 2);
        waitPops(6, 2, "etStartTimeout");
        @(posedge clk);
        #1;
        req = 8'h81;
        runUntilEmpty(60);

        // reset during beat 2 under backpressure; the next grant goes to lane 0, not lane 5
        applyReset(1, '0);
        applyStimulus(8'h04, 1'b1);
        pushBeat(2, 1'b0, 0);
        waitPops(2, 2, "mrStartTimeout");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        applyStimulus(8'h25, 1'b0);
        @(negedge clk);
        checkOutput("mrHoldPop", 64'(pop), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("mrValid", 64'(out_valid), 64'h0);
        checkOutput("mrBusy", 64'(busy), 64'h0);
        checkOutput("mrData", out_data, 64'h0);
        checkOutput("mrQueue", 64'(sbQ.size()), 64'h0);
        syncExpected();
        pushBurst(0, 0);
        runUntilEmpty(40);

        $display("test done: total=%0d bad=%0d", checkCount, failCount);
        $finish;
    end

endmodule
